trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_MAX, default 15, meaning max cycles spent in DRAIN before forced commit.
REQ-002 SHALL have ports:
 - ctrl_clk  in  1  clock; one clock, all state on rising edge.
 - ctrl_reset_n  in  1  reset, asynchronous, active-low.
 - exc_valid  in  1  synchronous exception present (level).
 - exc_code  in  4  exception cause.
 - exc_pc  in  32  PC of faulting instruction.
 - mret_req  in  1  mret retiring (level).
 - next_pc  in  32  PC of next unretired instruction.
 - irq_ext, irq_sw, irq_timer  in  1 each  raw interrupt lines.
 - csr_mie  in  1  global interrupt enable from CSR file.
 - csr_mxie  in  3  per-source enables {timer,sw,ext}.
 - csr_mtvec, csr_mepc  in  32 each  current CSR values.
 - pipe_drained  in  1  pipeline empty, no CSR write in flight.
 - ctrl_mxip  out  3  pending {timer,sw,ext} to CSR file.
 - flush_req  out  1  kill/hold fetch and younger instructions.
 - ctrl_trap, ctrl_mret  out  1 each  CSR commit strobes.
 - trap_info  out  5  {is_irq, cause[3:0]}.
 - trap_pc  out  32  value for mepc.
 - redirect_valid  out  1  one-cycle fetch redirect.
 - redirect_pc  out  32  redirect target.
 - drain_timeout  out  1  sticky watchdog flag.

Function
REQ-003 SHALL use FSM IDLE, DRAIN, COMMIT, REDIRECT; IDLE->DRAIN on accepted event; DRAIN->COMMIT when pipe_drained=1 or drain counter reaches DRAIN_MAX; COMMIT->REDIRECT->IDLE unconditionally.
REQ-004 SHALL sample events only in IDLE; priority exception > mret > interrupt; all inputs ignored in other states.
REQ-005 SHALL take an interrupt when csr_mie=1 and (ctrl_mxip & csr_mxie)!=0; among sources ext(cause 11) > sw(3) > timer(7).
REQ-006 SHALL latch kind, trap_info and trap_pc on acceptance: exception -> {0,exc_code}, exc_pc; interrupt -> {1,cause}, next_pc; mret -> trap_info 0, trap_pc 0.
REQ-007 SHALL hold flush_req=1 throughout DRAIN, COMMIT and REDIRECT.
REQ-008 SHALL pulse ctrl_trap for exactly the COMMIT cycle; for mret SHALL pulse ctrl_trap and ctrl_mret together.
REQ-009 SHALL compute redirect_pc in REDIRECT: mret -> csr_mepc; trap with csr_mtvec[1:0]=1 and interrupt -> {csr_mtvec[31:2],2'b00}+4*cause; otherwise {csr_mtvec[31:2],2'b00}.
REQ-010 SHALL set drain_timeout when COMMIT is entered via counter expiry; cleared only by reset.
REQ-011 SHALL give minimum event-to-redirect latency of 3 cycles (accept, COMMIT, REDIRECT) when pipe_drained is already 1.
REQ-012 SHALL treat an interrupt line deasserting during DRAIN as still taken (cause already latched).

Reset
REQ-013 SHALL, on ctrl_reset_n=0 at any time, enter IDLE with all outputs, latches, counter and synchronizer flops 0; an in-progress trap is abandoned with no strobe.

Configuration
REQ-014 With TRAP_CTRL_IRQ_SYNC_EN defined, each irq line SHALL pass a 2-flop synchronizer then a register (3-cycle line-to-ctrl_mxip latency); without it, a single register (1 cycle).

Structure
REQ-015 SHALL place FSM state enum, cause constants (11,3,7) and mtvec mode constants in package trap_pkg.
REQ-016 SHALL instantiate sub-module irq_sync (parameterised-width 2-flop synchronizer) only when TRAP_CTRL_IRQ_SYNC_EN is defined.

Verification
REQ-017 exc_valid=1, exc_code=2, exc_pc=0x100, pipe_drained=1, mtvec=0x80 -> ctrl_trap one cycle with trap_info=0x02, trap_pc=0x100; next cycle redirect_pc=0x80.
REQ-018 mtvec=0x81, csr_mie=1, mxie=3'b111, irq_timer=1 -> trap_info=0x17, trap_pc=next_pc, redirect_pc=0x9C.
REQ-019 irq_ext=irq_timer=1 with exc_valid=1 same cycle -> exception taken (is_irq=0); after return, ext (cause 11) taken before timer.
REQ-020 mret_req=1, csr_mepc=0x2000 -> ctrl_trap and ctrl_mret high together one cycle; redirect_pc=0x2000.
REQ-021 pipe_drained held 0 -> COMMIT after DRAIN_MAX=15 DRAIN cycles, drain_timeout=1 until reset.
REQ-022 ctrl_reset_n pulsed low during DRAIN -> no ctrl_trap, all outputs 0, FSM IDLE; irq latency checked as 3 or 1 cycles per macro.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
// FSM states, event kinds, interrupt causes and mtvec modes.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    K_EXC,
    K_IRQ,
    K_MRET
  } kind_t;

  localparam logic [3:0] CAUSE_EXT   = 4'd11;
  localparam logic [3:0] CAUSE_SW    = 4'd3;
  localparam logic [3:0] CAUSE_TIMER = 4'd7;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  // pend is {timer,sw,ext}; ext wins, then sw, then timer
  function automatic logic [3:0] irq_cause(
    input logic [2:0] pend
  );
    logic [3:0] c;
    c = CAUSE_TIMER;
    if (pend[0]) c = CAUSE_EXT;
    else if (pend[1]) c = CAUSE_SW;
    return c;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle between the core pipeline/CSR file and the trap controller.
// master = core side, slave = trap_ctrl.
interface trap_ctrl_if;

  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc;
  logic        mret_req;
  logic [31:0] next_pc;
  logic        irq_ext;
  logic        irq_sw;
  logic        irq_timer;
  logic        csr_mie;
  logic [2:0]  csr_mxie;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        pipe_drained;

  logic [2:0]  ctrl_mxip;
  logic        flush_req;
  logic        ctrl_trap;
  logic        ctrl_mret;
  logic [4:0]  trap_info;
  logic [31:0] trap_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        drain_timeout;

  modport master (
    output exc_valid, exc_code, exc_pc,
    output mret_req, next_pc,
    output irq_ext, irq_sw, irq_timer,
    output csr_mie, csr_mxie,
    output csr_mtvec, csr_mepc,
    output pipe_drained,
    input  ctrl_mxip, flush_req,
    input  ctrl_trap, ctrl_mret,
    input  trap_info, trap_pc,
    input  redirect_valid, redirect_pc,
    input  drain_timeout
  );

  modport slave (
    input  exc_valid, exc_code, exc_pc,
    input  mret_req, next_pc,
    input  irq_ext, irq_sw, irq_timer,
    input  csr_mie, csr_mxie,
    input  csr_mtvec, csr_mepc,
    input  pipe_drained,
    output ctrl_mxip, flush_req,
    output ctrl_trap, ctrl_mret,
    output trap_info, trap_pc,
    output redirect_valid, redirect_pc,
    output drain_timeout
  );

endinterface

// File: rtl/irq_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous
// interrupt lines.
module irq_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer: drain, commit, redirect.
// Build option TRAP_CTRL_IRQ_SYNC_EN adds a 2-flop irq synchronizer.
module trap_ctrl #(
  parameter int DRAIN_MAX = 15
) (
  input logic         ctrl_clk,
  input logic         ctrl_reset_n,
  trap_ctrl_if.slave  bus
);

  import trap_pkg::*;

  localparam int CW = $clog2(DRAIN_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(DRAIN_MAX - 1);

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    info_q, info_d;
  logic [31:0]   pc_q, pc_d;
  logic          tmo_q, tmo_set;
  logic          accept;

  logic [2:0]    irq_raw, irq_mid, mxip_q;
  logic [2:0]    pend;
  logic          irq_take;
  logic [31:0]   base;
  logic [31:0]   rpc;

  assign irq_raw = {bus.irq_timer, bus.irq_sw, bus.irq_ext};

`ifdef TRAP_CTRL_IRQ_SYNC_EN
  irq_sync #(
    .W (3)
  ) u_irq_sync (
    .clk   (ctrl_clk),
    .rst_n (ctrl_reset_n),
    .d     (irq_raw),
    .q     (irq_mid)
  );
`else
  assign irq_mid = irq_raw;
`endif

  assign pend     = mxip_q & bus.csr_mxie;
  assign irq_take = bus.csr_mie && (pend != 3'b000);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_set = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.exc_valid || bus.mret_req || irq_take) begin
          accept  = 1'b1;
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (bus.pipe_drained) begin
          state_d = ST_COMMIT;
        end else if (cnt_q == LAST) begin
          state_d = ST_COMMIT;
          tmo_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_COMMIT:   state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // What gets latched if this cycle's event is accepted
  always_comb begin
    kind_d = K_EXC;
    info_d = {1'b0, bus.exc_code};
    pc_d   = bus.exc_pc;
    if (bus.exc_valid) begin
      kind_d = K_EXC;
    end else if (bus.mret_req) begin
      kind_d = K_MRET;
      info_d = '0;
      pc_d   = '0;
    end else begin
      kind_d = K_IRQ;
      info_d = {1'b1, irq_cause(pend)};
      pc_d   = bus.next_pc;
    end
  end

  always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      kind_q  <= K_EXC;
      info_q  <= '0;
      pc_q    <= '0;
      tmo_q   <= 1'b0;
      mxip_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mxip_q  <= irq_mid;
      if (accept) begin
        kind_q <= kind_d;
        info_q <= info_d;
        pc_q   <= pc_d;
      end
      if (tmo_set) tmo_q <= 1'b1;
    end
  end

  assign base = {bus.csr_mtvec[31:2], 2'b00};

  always_comb begin
    rpc = '0;
    if (state_q == ST_REDIRECT) begin
      if (kind_q == K_MRET) begin
        rpc = bus.csr_mepc;
      end else if (kind_q == K_IRQ &&
                   bus.csr_mtvec[1:0] == MTVEC_VECTORED) begin
        rpc = base + {26'd0, info_q[3:0], 2'b00};
      end else begin
        rpc = base;
      end
    end
  end

  assign bus.ctrl_mxip      = mxip_q;
  assign bus.flush_req      = (state_q != ST_IDLE);
  assign bus.ctrl_trap      = (state_q == ST_COMMIT);
  assign bus.ctrl_mret      = (state_q == ST_COMMIT) &&
                              (kind_q == K_MRET);
  assign bus.trap_info      = info_q;
  assign bus.trap_pc        = pc_q;
  assign bus.redirect_valid = (state_q == ST_REDIRECT);
  assign bus.redirect_pc    = rpc;
  assign bus.drain_timeout  = tmo_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected commits are queued when
// an event is driven and retired at ctrl_trap / redirect_valid.
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trap_ctrl_if bus ();

  trap_ctrl #(
    .DRAIN_MAX (15)
  ) dut (
    .ctrl_clk     (clk),
    .ctrl_reset_n (rst_n),
    .bus          (bus)
  );

`ifdef TRAP_CTRL_IRQ_SYNC_EN
  localparam int IRQ_LAT = 3;
`else
  localparam int IRQ_LAT = 1;
`endif

  typedef struct {
    logic [4:0]  info;
    logic [31:0] pc;
    logic        mret;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;
  int total = 0;
  int bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rpc(
    input bit m, input bit irq, input logic [3:0] cause,
    input logic [31:0] tvec, input logic [31:0] epc);
    logic [31:0] b;
    b = {tvec[31:2], 2'b00};
    if (m) return epc;
    if (irq && tvec[1:0] == 2'b01) return b + 32'(cause) * 4;
    return b;
  endfunction

  task automatic push(input logic [4:0] info, input logic [31:0] pc,
                      input logic m, input logic [31:0] rpc);
    exp_t e;
    e.info = info;
    e.pc   = pc;
    e.mret = m;
    e.rpc  = rpc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ctrl_trap) begin
        if (sb.size() == 0) begin
          check("trap_unexpected", bus.ctrl_trap, 0);
        end else begin
          check("trap_info", bus.trap_info, sb[0].info);
          check("trap_pc", bus.trap_pc, sb[0].pc);
          check("ctrl_mret", bus.ctrl_mret, sb[0].mret);
          check("flush_commit", bus.flush_req, 1);
        end
      end
      if (bus.redirect_valid) begin
        if (sb.size() == 0) begin
          check("redir_unexpected", bus.redirect_valid, 0);
        end else begin
          e_pop = sb.pop_front();
          check("redirect_pc", bus.redirect_pc, e_pop.rpc);
          check("flush_redir", bus.flush_req, 1);
        end
      end
    end
  end

  task automatic settle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.flush_req) begin
        ok = 1;
        break;
      end
    end
    check("settle", ok, 1);
  endtask

  task automatic wait_flush(input bit lvl, input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.flush_req == lvl) begin
        ok = 1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  task automatic fire(input bit m, input logic [3:0] code,
                      input logic [31:0] pc, output int lat);
    @(posedge clk);
    #1;
    if (m) begin
      bus.mret_req = 1'b1;
    end else begin
      bus.exc_valid = 1'b1;
      bus.exc_code  = code;
      bus.exc_pc    = pc;
    end
    @(posedge clk);
    #1;
    bus.mret_req  = 1'b0;
    bus.exc_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.redirect_valid) begin
        lat = i;
        break;
      end
    end
    check("redirect_seen", lat != 0, 1);
    settle(10);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"},
          {bus.flush_req, bus.ctrl_trap, bus.ctrl_mret,
           bus.redirect_valid, bus.drain_timeout,
           bus.ctrl_mxip, bus.trap_info}, 0);
    check({tag, "_tpc"}, bus.trap_pc, 0);
    check({tag, "_rpc"}, bus.redirect_pc, 0);
  endtask

  initial begin
    int lat;
    int n;
    bit got;
    logic [31:0] tv, pcv, ep;
    logic [3:0] cd;
    bit m;

    bus.exc_valid    = 0;
    bus.exc_code     = 0;
    bus.exc_pc       = 0;
    bus.mret_req     = 0;
    bus.next_pc      = 0;
    bus.irq_ext      = 0;
    bus.irq_sw       = 0;
    bus.irq_timer    = 0;
    bus.csr_mie      = 0;
    bus.csr_mxie     = 0;
    bus.csr_mtvec    = 32'h80;
    bus.csr_mepc     = 0;
    bus.pipe_drained = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // synchronous exception, direct mode, minimum latency
    push(5'h02, 32'h100, 0, 32'h80);
    fire(0, 4'd2, 32'h100, lat);
    check("lat_exc", lat, 3);

    // timer irq, vectored; line drops while draining
    bus.csr_mtvec    = 32'h81;
    bus.csr_mie      = 1;
    bus.csr_mxie     = 3'b111;
    bus.next_pc      = 32'h4444;
    bus.pipe_drained = 0;
    push(5'h17, 32'h4444, 0, 32'h9C);
    @(posedge clk);
    #1;
    bus.irq_timer = 1;
    wait_flush(1, "tmr_accept");
    bus.irq_timer = 0;
    repeat (3) @(posedge clk);
    #1;
    check("flush_hold", bus.flush_req, 1);
    bus.pipe_drained = 1;
    settle(30);

    // exception beats irqs, then ext beats timer
    bus.next_pc = 32'h5000;
    push(5'h05, 32'h300, 0, 32'h80);
    push(5'h1B, 32'h5000, 0, 32'hAC);
    push(5'h17, 32'h5000, 0, 32'h9C);
    @(posedge clk);
    #1;
    bus.exc_valid = 1;
    bus.exc_code  = 4'd5;
    bus.exc_pc    = 32'h300;
    bus.irq_ext   = 1;
    bus.irq_timer = 1;
    @(posedge clk);
    #1;
    bus.exc_valid = 0;
    wait_flush(0, "exc_done");
    wait_flush(1, "ext_accept");
    bus.irq_ext = 0;
    wait_flush(0, "ext_done");
    wait_flush(1, "tmr2_accept");
    bus.irq_timer = 0;
    settle(30);

    // mret
    bus.csr_mie  = 0;
    bus.csr_mepc = 32'h2000;
    push(5'h00, 32'h0, 1, 32'h2000);
    fire(1, 4'd0, 32'h0, lat);
    check("lat_mret", lat, 3);

    // drain watchdog
    check("tmo_before", bus.drain_timeout, 0);
    bus.csr_mtvec    = 32'h80;
    bus.pipe_drained = 0;
    push(5'h01, 32'h40, 0, 32'h80);
    @(posedge clk);
    #1;
    bus.exc_valid = 1;
    bus.exc_code  = 4'd1;
    bus.exc_pc    = 32'h40;
    @(posedge clk);
    #1;
    bus.exc_valid = 0;
    n = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ctrl_trap) begin
        got = 1;
        break;
      end
      n++;
    end
    check("drain_commit", got, 1);
    check("drain_cycles", n, 15);
    check("tmo_set", bus.drain_timeout, 1);
    settle(10);
    bus.pipe_drained = 1;
    push(5'h04, 32'h44, 0, 32'h80);
    fire(0, 4'd4, 32'h44, lat);
    check("tmo_sticky", bus.drain_timeout, 1);

    // mixed exceptions / mrets
    for (int k = 0; k < 6; k++) begin
      tv  = $urandom;
      pcv = $urandom;
      ep  = $urandom;
      cd  = 4'($urandom);
      m   = ($urandom_range(0, 3) == 0);
      bus.csr_mtvec    = tv;
      bus.csr_mepc     = ep;
      bus.pipe_drained = 1'($urandom_range(0, 1));
      push(m ? 5'd0 : {1'b0, cd}, m ? 32'd0 : pcv, m,
           model_rpc(m, 0, cd, tv, ep));
      fire(m, cd, pcv, lat);
      if (bus.pipe_drained) check("lat_rand", lat, 3);
    end
    bus.pipe_drained = 1;

    // irq line to ctrl_mxip latency (globally disabled)
    @(posedge clk);
    #1;
    bus.irq_sw = 1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.ctrl_mxip[1]) begin
        n = i;
        break;
      end
    end
    check("irq_lat", n, IRQ_LAT);
    check("mxip", bus.ctrl_mxip, 3'b010);
    bus.irq_sw = 0;
    repeat (5) @(posedge clk);
    #1;
    check("mxip_clr", bus.ctrl_mxip, 0);

    // reset during drain abandons the trap
    bus.pipe_drained = 0;
    @(posedge clk);
    #1;
    bus.exc_valid = 1;
    bus.exc_code  = 4'd3;
    bus.exc_pc    = 32'h77;
    @(posedge clk);
    #1;
    bus.exc_valid = 0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_flush", bus.flush_req, 1);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.pipe_drained = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ctrl_trap || bus.flush_req) n++;
    end
    check("post_rst_quiet", n, 0);
    check_zero("post_rst");
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
